seg_scan_ctrl: RTL and testbench

//  Time-multiplexes one shared, active-low 7-segment bus (io_seg) across DIGITS

---
 rtl/seg_pkg.sv | 23 ++
 rtl/hex_seg_decode.sv | 14 +
 rtl/seg_scan_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller.
//  - SEG_LUT : hex nibble -> active-high segments {g,f,e,d,c,b,a}
//  - SEG_OFF : value that turns every segment (and dp) off on the active-low bus
//  - scan_state_t : scan FSM states
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Index is the nibble value; bit 0 = segment a ... bit 6 = segment g.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // BLANK: all digits off (anti-ghosting gap); DRIVE: current digit lit.
    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/hex_seg_decode.sv
// Purely combinational hex to 7-segment decoder.
// Ports:
//  i_nibble  in  4  hex digit
//  o_seg     out 7  active-high segments {g,f,e,d,c,b,a}
module hex_seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_LUT[i_nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for DIGITS common-anode digits sharing one
// active-low segment bus. Each digit slot lasts TICK_CYCLES clocks, of which
// the first BLANK_CYCLES keep every digit off to avoid ghosting. New display
// contents are captured into a shadow register on 'load' and only copied to
// the display registers at a frame boundary, so a frame never tears.
//
// Handshake: 'load' is a single-cycle strobe with no back-pressure; it is
// always accepted. update_pending stays high from the edge after a load until
// the frame boundary that makes the shadow visible.
//
// Ports:
//  clk             in   1          system clock
//  rst             in   1          synchronous, active-high reset
//  value_in        in   4*DIGITS   hex nibbles, digit d = value_in[4d+3:4d]
//  dp_in           in   DIGITS     decimal point per digit, 1 = lit
//  blank_in        in   DIGITS     1 = digit dark for its whole slot
//  load            in   1          capture value/dp/blank into the shadow
//  update_pending  out  1          shadow captured, not yet displayed
//  frame_done      out  1          high during the frame-boundary cycle
//  io_sel          out  DIGITS     digit enables, active-low
//  io_seg          out  8          {dp,g,f,e,d,c,b,a}, active-low
//  o_dbg_state     out  1          current scan FSM state
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int TICK_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  load,
    output logic                  update_pending,
    output logic                  frame_done,
    output logic [DIGITS-1:0]     io_sel,
    output logic [7:0]            io_seg,
    output scan_state_t           o_dbg_state
);

    localparam int CW = $clog2(TICK_CYCLES);
    localparam int IW = $clog2(DIGITS);

    localparam logic [CW-1:0] CNT_LAST   = CW'(TICK_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    scan_state_t          r_state;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;

    logic [4*DIGITS-1:0]  r_sh_value;
    logic [DIGITS-1:0]    r_sh_dp;
    logic [DIGITS-1:0]    r_sh_blank;
    logic                 r_pending;

    logic [4*DIGITS-1:0]  r_disp_value;
    logic [DIGITS-1:0]    r_disp_dp;
    logic [DIGITS-1:0]    r_disp_blank;

    logic [DIGITS-1:0]    r_sel;
    logic [7:0]           r_seg;
    logic                 r_frame_done;

    scan_state_t          w_state_nx;
    logic [CW-1:0]        w_cnt_nx;
    logic [IW-1:0]        w_idx_nx;
    logic                 w_boundary;
    logic                 w_boundary_nx;
    logic [3:0]           w_nibble;
    logic [6:0]           w_seg7;

    // ---------------------------------------------------------------
    // Scan FSM: next state, slot counter and digit index
    // ---------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_cnt_nx   = (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
        case (r_state)
            BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_state_nx = DRIVE;
                end
            end
            DRIVE: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nx = BLANK;
                    w_idx_nx   = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
                end
            end
            default: w_state_nx = BLANK;
        endcase
    end

    // This cycle ends the frame: last cycle of the last digit's DRIVE.
    assign w_boundary = (r_state == DRIVE) && (r_cnt == CNT_LAST) && (r_idx == IDX_LAST);

    // Look-ahead of w_boundary so the registered frame_done lines up with the
    // boundary cycle itself.
    assign w_boundary_nx = (w_state_nx == DRIVE) && (w_cnt_nx == CNT_LAST) &&
                           (w_idx_nx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
        end
    end

    // ---------------------------------------------------------------
    // Shadow and display registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_value   <= '0;
            r_sh_dp      <= '0;
            r_sh_blank   <= '0;
            r_pending    <= 1'b0;
            r_disp_value <= '0;
            r_disp_dp    <= '0;
            r_disp_blank <= '0;
        end else if (load && w_boundary) begin
            // Load on the boundary itself: bypass the shadow, nothing left pending.
            r_sh_value   <= value_in;
            r_sh_dp      <= dp_in;
            r_sh_blank   <= blank_in;
            r_disp_value <= value_in;
            r_disp_dp    <= dp_in;
            r_disp_blank <= blank_in;
            r_pending    <= 1'b0;
        end else begin
            if (w_boundary && r_pending) begin
                r_disp_value <= r_sh_value;
                r_disp_dp    <= r_sh_dp;
                r_disp_blank <= r_sh_blank;
                r_pending    <= 1'b0;
            end
            if (load) begin
                r_sh_value <= value_in;
                r_sh_dp    <= dp_in;
                r_sh_blank <= blank_in;
                r_pending  <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Output registers, computed from the next scan position so the pins
    // change on the same edge as the FSM. The display regs only change on
    // the edge into BLANK, so the current copy is valid for any DRIVE slot.
    // ---------------------------------------------------------------
    assign w_nibble = r_disp_value[{w_idx_nx, 2'b00} +: 4];

    hex_seg_decode u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_seg7)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel        <= '1;
            r_seg        <= SEG_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_boundary_nx;
            if (w_state_nx == DRIVE && !r_disp_blank[w_idx_nx]) begin
                r_sel <= ~(DIGITS'(1) << w_idx_nx);
                r_seg <= ~{r_disp_dp[w_idx_nx], w_seg7};
            end else begin
                r_sel <= '1;
                r_seg <= SEG_OFF;
            end
        end
    end

    assign io_sel         = r_sel;
    assign io_seg         = r_seg;
    assign frame_done     = r_frame_done;
    assign update_pending = r_pending;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with DIGITS=4, TICK_CYCLES=8, BLANK_CYCLES=2.
// One frame is 32 cycles; 'pos' is the scan position 0..31 the DUT should be
// showing after each clock edge. Expected segment bytes are hand-computed.
module tb_seg_scan_ctrl;
    import seg_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic [15:0]   value_in = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    blank_in = '0;
    logic          load = 1'b0;
    logic          update_pending;
    logic          frame_done;
    logic [3:0]    io_sel;
    logic [7:0]    io_seg;
    scan_state_t   dbg_state;

    seg_scan_ctrl #(
        .DIGITS       (4),
        .TICK_CYCLES  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .value_in       (value_in),
        .dp_in          (dp_in),
        .blank_in       (blank_in),
        .load           (load),
        .update_pending (update_pending),
        .frame_done     (frame_done),
        .io_sel         (io_sel),
        .io_seg         (io_seg),
        .o_dbg_state    (dbg_state)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [31:0] seg;   // expected io_seg per digit, digit d at [8d+7:8d]
    } vec_t;

    vec_t tbl [8];

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    int          pos      = 0;
    logic [31:0] cur_seg  = 32'hC0C0C0C0;
    logic [3:0]  cur_blank = '0;
    logic [31:0] sh_seg   = 32'hC0C0C0C0;
    logic [3:0]  sh_blank = '0;
    logic        exp_pending = 1'b0;
    logic [31:0] ld_seg   = '0;
    logic [3:0]  ld_blank = '0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s pos=%0d t=%0t actual=%h expected=%h", name, pos, $time, act, exp);
        end
    endtask

    // Expected-state update at each rising edge.
    task automatic model_edge();
        logic boundary;
        boundary = (pos == 31);
        if (rst) begin
            pos         = 0;
            exp_pending = 1'b0;
            cur_seg     = 32'hC0C0C0C0;
            cur_blank   = '0;
            sh_seg      = 32'hC0C0C0C0;
            sh_blank    = '0;
        end else begin
            if (load && boundary) begin
                cur_seg     = ld_seg;
                cur_blank   = ld_blank;
                exp_pending = 1'b0;
            end else begin
                if (boundary && exp_pending) begin
                    cur_seg     = sh_seg;
                    cur_blank   = sh_blank;
                    exp_pending = 1'b0;
                end
                if (load) begin
                    sh_seg      = ld_seg;
                    sh_blank    = ld_blank;
                    exp_pending = 1'b1;
                end
            end
            pos = (pos + 1) % 32;
        end
    endtask

    task automatic check_outputs();
        int slot;
        int cnt;
        logic [3:0] esel;
        logic [7:0] eseg;
        slot = pos / 8;
        cnt  = pos % 8;
        if (cnt < 2 || cur_blank[slot]) begin
            esel = 4'hF;
            eseg = 8'hFF;
        end else begin
            esel = ~(4'b0001 << slot);
            eseg = cur_seg[slot*8 +: 8];
        end
        chk("io_sel", {4'h0, io_sel}, {4'h0, esel});
        chk("io_seg", io_seg, eseg);
        chk("frame_done", {7'h0, frame_done}, {7'h0, (pos == 31)});
        chk("update_pending", {7'h0, update_pending}, {7'h0, exp_pending});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_load(input int i);
        value_in = tbl[i].value;
        dp_in    = tbl[i].dp;
        blank_in = tbl[i].blank;
        ld_seg   = tbl[i].seg;
        ld_blank = tbl[i].blank;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        int guard;
        guard = 0;
        while (pos != p && guard < 64) begin
            tick();
            guard++;
        end
        n_checks++;
        if (pos != p) begin
            n_fail++;
            $display("FAIL wait_pos actual=%0d expected=%0d", pos, p);
        end
    endtask

    task automatic run_frames(input int n);
        repeat (32 * n) tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        tbl[0] = '{16'h0000, 4'b0000, 4'b0000, 32'hC0C0C0C0};
        tbl[1] = '{16'h8005, 4'b1000, 4'b0000, 32'h00C0C092};
        tbl[2] = '{16'h1234, 4'b0000, 4'b0010, 32'hF9A4FF99};
        tbl[3] = '{16'hFEDC, 4'b0101, 4'b0000, 32'h8E06A146};
        tbl[4] = '{16'h6543, 4'b0000, 4'b0000, 32'h829299B0};
        tbl[5] = '{16'h1111, 4'b0000, 4'b0000, 32'hF9F9F9F9};
        tbl[6] = '{16'h2222, 4'b0000, 4'b0000, 32'hA4A4A4A4};
        tbl[7] = '{16'h9A7B, 4'b0000, 4'b0000, 32'h9088F883};

        // Reset for 3 cycles, then first digit-0 drive two edges after release.
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_sel", {4'h0, io_sel}, 8'h0F);
        chk("reset_seg", io_seg, 8'hFF);
        rst = 1'b0;
        tick();
        chk("release_blank_sel", {4'h0, io_sel}, 8'h0F);
        tick();
        chk("first_drive_sel", {4'h0, io_sel}, 8'h0E);
        chk("first_drive_seg", io_seg, 8'hC0);

        // Table vectors: load mid-frame (digit-1 slot), old frame must hold,
        // then one full frame of the new contents.
        for (int i = 0; i < 5; i++) begin
            wait_pos(10);
            do_load(i);
            wait_pos(0);
            run_frames(1);
        end

        // Two loads in one frame: last one wins.
        wait_pos(5);
        do_load(5);
        wait_pos(15);
        do_load(6);
        wait_pos(0);
        chk("two_loads_d0", io_seg, 8'hFF);
        run_frames(1);

        // Load coincident with frame_done goes straight to the display.
        wait_pos(31);
        chk("boundary_frame_done", {7'h0, frame_done}, 8'h01);
        do_load(7);
        chk("boundary_no_pending", {7'h0, update_pending}, 8'h00);
        run_frames(1);

        // Reset during digit-2 DRIVE with an update pending.
        wait_pos(3);
        do_load(1);
        wait_pos(18);
        chk("pre_reset_pending", {7'h0, update_pending}, 8'h01);
        chk("pre_reset_sel", {4'h0, io_sel}, 8'h0B);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post_reset_pending", {7'h0, update_pending}, 8'h00);
        chk("post_reset_sel", {4'h0, io_sel}, 8'h0F);
        chk("post_reset_seg", io_seg, 8'hFF);
        chk("post_reset_state", {7'h0, dbg_state}, {7'h0, BLANK});
        run_frames(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
